// File: rtl/game_pkg.sv
// Shared definitions for the cursor/selection control slice.
//   COORD_W     : width of every tile coordinate
//   sel_state_e : selection FSM states (IDLE, FIRST, REQ)
//   dir_e       : arbitrated move direction (NONE, UP, RIGHT, DOWN, LEFT)
package game_pkg;

    localparam int COORD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        REQ
    } sel_state_e;

    typedef enum logic [2:0] {
        NONE,
        UP,
        RIGHT,
        DOWN,
        LEFT
    } dir_e;

endpackage

// File: rtl/btn_edge_sync.sv
// Button resynchroniser with press detection.
//   clk, rst_n : system clock, synchronous active-low reset
//   i_btn      : debounced button level, asynchronous to clk
//   o_level    : synchronised level (two flops after i_btn)
//   o_rise     : one-cycle pulse on a 0->1 of the synchronised level
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // The pulse is built only from flopped values, so the consumer that
    // registers it acts on the third clk edge after the input edge.
    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/cursor_select_ctrl.sv
// Turns debounced buttons into cursor moves and two-tile match requests.
//   clk, rst_n                 : system clock, synchronous active-low reset
//   up_in/right_in/down_in/left_in/s_in : debounced button levels (async)
//   en                         : 0 freezes cursor/selection, ignores presses
//   cur_x, cur_y               : cursor position
//   sel_valid, sel_x, sel_y    : first selected tile
//   req_valid, req_x0..req_y1  : pending pair request (first, second)
//   req_ready                  : downstream accepts the request
module cursor_select_ctrl
    import game_pkg::*;
#(
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int TICK_DIV = 100000,
    parameter int HOLD_MS  = 400,
    parameter int RPT_MS   = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_in,
    input  logic               right_in,
    input  logic               down_in,
    input  logic               left_in,
    input  logic               s_in,
    input  logic               en,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y,
    output logic               sel_valid,
    output logic [COORD_W-1:0] sel_x,
    output logic [COORD_W-1:0] sel_y,
    output logic               req_valid,
    output logic [COORD_W-1:0] req_x0,
    output logic [COORD_W-1:0] req_y0,
    output logic [COORD_W-1:0] req_x1,
    output logic [COORD_W-1:0] req_y1,
    input  logic               req_ready
);

    if (COLS < 2 || COLS > 16 || ROWS < 2 || ROWS > 16 ||
        TICK_DIV < 1 || HOLD_MS < 1 || RPT_MS < 1) begin : g_bad_params
        $error("cursor_select_ctrl: COLS/ROWS must be 2..16, timers >= 1");
    end

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MS_MAX = (HOLD_MS > RPT_MS) ? HOLD_MS : RPT_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam logic [COORD_W-1:0] MAX_X = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(ROWS - 1);

    // ---------------- button front end (0 up, 1 right, 2 down, 3 left)
    logic [3:0] w_lvl;
    logic [4:0] w_rise;
    logic       w_unused_s_lvl;

    btn_edge_sync u_up    (.clk(clk), .rst_n(rst_n), .i_btn(up_in),    .o_level(w_lvl[0]),       .o_rise(w_rise[0]));
    btn_edge_sync u_right (.clk(clk), .rst_n(rst_n), .i_btn(right_in), .o_level(w_lvl[1]),       .o_rise(w_rise[1]));
    btn_edge_sync u_down  (.clk(clk), .rst_n(rst_n), .i_btn(down_in),  .o_level(w_lvl[2]),       .o_rise(w_rise[2]));
    btn_edge_sync u_left  (.clk(clk), .rst_n(rst_n), .i_btn(left_in),  .o_level(w_lvl[3]),       .o_rise(w_rise[3]));
    btn_edge_sync u_sel   (.clk(clk), .rst_n(rst_n), .i_btn(s_in),     .o_level(w_unused_s_lvl), .o_rise(w_rise[4]));

    // ---------------- 1 ms tick
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ---------------- arbitration and auto-repeat
    dir_e            w_press_dir;
    dir_e            w_move_dir;
    dir_e            r_hold_dir;
    logic [MS_W-1:0] r_ms_cnt;
    logic            r_rpt_phase;   // 0: waiting HOLD_MS, 1: repeating every RPT_MS
    logic            w_hold_lvl;
    logic            w_rpt_fire;
    logic [MS_W-1:0] w_limit_m1;
    sel_state_e      r_state;
    sel_state_e      w_state_nxt;

    always_comb begin
        w_press_dir = NONE;
        if (en) begin
            if      (w_rise[0]) w_press_dir = UP;
            else if (w_rise[1]) w_press_dir = RIGHT;
            else if (w_rise[2]) w_press_dir = DOWN;
            else if (w_rise[3]) w_press_dir = LEFT;
        end
    end

    always_comb begin
        w_hold_lvl = 1'b0;
        case (r_hold_dir)
            UP:      w_hold_lvl = w_lvl[0];
            RIGHT:   w_hold_lvl = w_lvl[1];
            DOWN:    w_hold_lvl = w_lvl[2];
            LEFT:    w_hold_lvl = w_lvl[3];
            default: w_hold_lvl = 1'b0;
        endcase
    end

    assign w_limit_m1 = r_rpt_phase ? MS_W'(RPT_MS - 1) : MS_W'(HOLD_MS - 1);
    assign w_rpt_fire = en && (r_hold_dir != NONE) && w_hold_lvl && w_tick &&
                        (r_ms_cnt == w_limit_m1);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_hold_dir  <= NONE;
            r_ms_cnt    <= '0;
            r_rpt_phase <= 1'b0;
        end else if (w_press_dir != NONE) begin
            r_hold_dir  <= w_press_dir;
            r_ms_cnt    <= '0;
            r_rpt_phase <= 1'b0;
        end else if (r_hold_dir != NONE && !w_hold_lvl) begin
            r_hold_dir  <= NONE;
            r_ms_cnt    <= '0;
            r_rpt_phase <= 1'b0;
        end else if (r_hold_dir != NONE && w_tick) begin
            if (w_rpt_fire) begin
                r_ms_cnt    <= '0;
                r_rpt_phase <= 1'b1;
            end else begin
                r_ms_cnt    <= r_ms_cnt + 1'b1;
            end
        end
    end

    // ---------------- cursor
    logic [COORD_W-1:0] r_cur_x, r_cur_y;
    logic [COORD_W-1:0] w_nx, w_ny;

    always_comb begin
        w_move_dir = NONE;
        if (r_state != REQ) begin
            if (w_press_dir != NONE) w_move_dir = w_press_dir;
            else if (w_rpt_fire)     w_move_dir = r_hold_dir;
        end
    end

    always_comb begin
        w_nx = r_cur_x;
        w_ny = r_cur_y;
        case (w_move_dir)
            UP:      if (r_cur_y != '0)   w_ny = r_cur_y - 1'b1;
            DOWN:    if (r_cur_y != MAX_Y) w_ny = r_cur_y + 1'b1;
            LEFT:    if (r_cur_x != '0)   w_nx = r_cur_x - 1'b1;
            RIGHT:   if (r_cur_x != MAX_X) w_nx = r_cur_x + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else begin
            r_cur_x <= w_nx;
            r_cur_y <= w_ny;
        end
    end

    // ---------------- selection FSM
    // Selection compares against the post-move cursor so a select pressed
    // together with a move acts on the tile the cursor lands on.
    logic w_s_press;
    logic w_load_sel, w_cancel, w_load_req, w_done;
    logic r_sel_valid, r_req_valid;
    logic [COORD_W-1:0] r_sel_x, r_sel_y, r_x0, r_y0, r_x1, r_y1;

    assign w_s_press = en && w_rise[4];

    always_comb begin
        w_state_nxt = r_state;
        w_load_sel  = 1'b0;
        w_cancel    = 1'b0;
        w_load_req  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s_press) begin
                    w_load_sel  = 1'b1;
                    w_state_nxt = FIRST;
                end
            end
            FIRST: begin
                if (w_s_press) begin
                    if (w_nx == r_sel_x && w_ny == r_sel_y) begin
                        w_cancel    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_load_req  = 1'b1;
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (r_req_valid && req_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_valid <= 1'b0;
            r_sel_x     <= '0;
            r_sel_y     <= '0;
            r_req_valid <= 1'b0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_x1        <= '0;
            r_y1        <= '0;
        end else begin
            if (w_load_sel) begin
                r_sel_valid <= 1'b1;
                r_sel_x     <= w_nx;
                r_sel_y     <= w_ny;
            end
            if (w_cancel || w_done) r_sel_valid <= 1'b0;
            if (w_load_req) begin
                r_req_valid <= 1'b1;
                r_x0        <= r_sel_x;
                r_y0        <= r_sel_y;
                r_x1        <= w_nx;
                r_y1        <= w_ny;
            end
            if (w_done) r_req_valid <= 1'b0;
        end
    end

    assign cur_x     = r_cur_x;
    assign cur_y     = r_cur_y;
    assign sel_valid = r_sel_valid;
    assign sel_x     = r_sel_x;
    assign sel_y     = r_sel_y;
    assign req_valid = r_req_valid;
    assign req_x0    = r_x0;
    assign req_y0    = r_y0;
    assign req_x1    = r_x1;
    assign req_y1    = r_y1;

endmodule

// File: doc/cursor_select_ctrl.md
Name: cursor_select_ctrl

Overview:
- Consumes the five debounced button levels (up/right/down/left/select) and turns them into game actions: cursor moves on the tile grid and two-tile match requests.
- Sits between the debounce front end and the board/match-check logic.
- Provides resynchronisation, press-edge detection, hold-to-repeat on directions, cursor bookkeeping and a valid/ready handshake that hands a selected tile pair downstream.

Parameters:
- COLS, 8, grid width in tiles (2..16)
- ROWS, 8, grid height in tiles (2..16)
- TICK_DIV, 100000, clk cycles per 1 ms repeat tick
- HOLD_MS, 400, ms a direction must be held before auto-repeat starts
- RPT_MS, 100, ms between auto-repeat moves

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- up_in, right_in, down_in, left_in, s_in  in  1 each  debounced button levels, asynchronous to clk
- en  in  1  accept input; 0 freezes cursor and selection and ignores presses
- cur_x  out  4  cursor column, 0..COLS-1
- cur_y  out  4  cursor row, 0..ROWS-1
- sel_valid  out  1  first tile held
- sel_x, sel_y  out  4 each  first tile coordinates
- req_valid  out  1  pair request pending
- req_x0, req_y0, req_x1, req_y1  out  4 each  pair coordinates, first then second
- req_ready  in  1  downstream accepts the request

Behaviour:
- Reset: rst_n low at a clk edge sets all outputs to 0, state IDLE, and clears counters and synchroniser flops. This applies mid-operation too; a pending req_valid is dropped.
- Sync: each button input passes through a 2-flop synchroniser. A press is a 0->1 on the synchronised level, registered, so each action lands 3 clk cycles after the input edge.
- Tick: a free-running counter over 0..TICK_DIV-1 produces a 1-cycle tick at TICK_DIV-1.
- Direction arbitration: only one move per cycle, with fixed priority up > right > down > left. A lower-priority press coincident with a higher one is discarded, not queued.
- Auto-repeat:
  - The winning direction is held in a hold register.
  - While that direction stays high, a ms counter runs on ticks.
  - At HOLD_MS it issues a repeat move, then reloads for RPT_MS and repeats at that period.
  - Releasing the held direction, or pressing a different direction, restarts the sequence.
- Moves:
  - up: y-1. down: y+1. left: x-1. right: x+1.
  - Moves saturate at the grid edges with no wrap. A move at an edge leaves the cursor unchanged and is not an error.
- Selection FSM:
  - IDLE:
    - s press latches the cursor into sel_x/sel_y, sets sel_valid=1, and goes to FIRST.
  - FIRST: cursor moves remain allowed.
    - s press on the same tile as sel cancels: sel_valid=0, go to IDLE.
    - s press on a different tile loads the req_* fields (x0,y0 = sel; x1,y1 = cursor), sets req_valid=1, and goes to REQ.
  - REQ:
    - Cursor moves and s presses are ignored. Presses are not buffered.
    - req_* are stable while req_valid=1.
    - On a cycle with req_valid && req_ready, the next cycle has req_valid=0, sel_valid=0 and state IDLE.
- en=0:
  - Presses are consumed and discarded, and the repeat counters are held cleared.
  - A pending REQ handshake still completes, because req_ready is honoured regardless of en.
- Simultaneous s press and direction press in the same cycle: the move applies first, then s uses the post-move cursor. Both are registered in that cycle, so s selects the new tile.
- Width rule: coordinates are 4 bits. COLS or ROWS above 16 is illegal and must be rejected by an elaboration-time check.

Decomposition:
- Shared package (game_pkg):
  - COORD_W=4
  - the FSM state enum IDLE/FIRST/REQ
  - the direction encoding NONE/UP/RIGHT/DOWN/LEFT
- One natural sub-module, btn_edge_sync: 2-flop sync plus registered rise pulse, instantiated five times.
- Arbitration, repeat timers, cursor and FSM stay in the top.

Test Plan:
- Reset, then pulse right_in 3 times (each held 2 ms, HOLD_MS=400) -> cur_x=3, cur_y=0, no repeat; right_in rising edge -> cur_x changes 3 clk later.
- Hold down_in 650 ms at cursor (0,0), HOLD_MS=400, RPT_MS=100, ROWS=8 -> moves at 0, 400, 500, 600 ms -> cur_y=4; release stops movement.
- At (7,7) with COLS=ROWS=8, press right then down -> stays (7,7). At (0,0), press up and left together -> only up is evaluated, cursor unchanged.
- s at (2,3), s again at (2,3) -> sel_valid rises then clears, req_valid never asserts. s at (2,3), move to (5,3), s -> req_valid=1 with x0,y0=2,3 and x1,y1=5,3. Hold req_ready=0 for 10 cycles -> outputs stable and moves ignored. Assert req_ready -> req_valid=0 and IDLE next cycle.
- With req_valid=1, drive rst_n=0 for one clk -> all outputs 0 next cycle. Separately, en=0 with presses -> no change, while a pending req still completes on req_ready.
